// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace packer: record layout, type codes,
// statistic counter indices and the packer FSM states.
package trace_pkg;

    localparam logic [2:0] REC_REG   = 3'd1;
    localparam logic [2:0] REC_LOAD  = 3'd2;
    localparam logic [2:0] REC_STORE = 3'd3;
    localparam logic [2:0] REC_HALT  = 3'd4;
    localparam logic [2:0] REC_COUNT = 3'd5;

    localparam logic [2:0] CNT_CYCLES = 3'd0;
    localparam logic [2:0] CNT_INST   = 3'd1;
    localparam logic [2:0] CNT_IHIT   = 3'd2;
    localparam logic [2:0] CNT_DHIT   = 3'd3;
    localparam logic [2:0] CNT_IREQ   = 3'd4;
    localparam logic [2:0] CNT_DREQ   = 3'd5;
    localparam logic [2:0] CNT_DROPS  = 3'd6;

    localparam int NUM_CNT = 7;
    localparam int MAX_EV  = 4;
    localparam int REC_W   = 3 + 3 + 32;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [2:0]  rtype;
        logic [2:0]  id;
        logic [31:0] data;
    } rec_t;

    function automatic rec_t make_rec(input logic [2:0] rtype, input logic [2:0] id,
                                      input logic [31:0] data);
        rec_t r;
        r.rtype = rtype;
        r.id    = id;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer accepting up to four pushes per cycle and one pop.
// The caller guarantees pushes fit; count reflects occupancy before this cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                push_cnt,
    input  rec_t [MAX_EV-1:0]         push_rec,
    input  logic                      pop,
    output rec_t                      head,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_pop;
    rec_t          slot_rd [DEPTH];

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(push_cnt) - (PW+1)'(do_pop);
        end
    end

    // Each slot picks whichever push lane lands on it this cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        rec_t slot_q;
        logic we;
        rec_t wd;

        always_comb begin
            we = 1'b0;
            wd = '0;
            for (int k = 0; k < MAX_EV; k++) begin
                if ((3'(k) < push_cnt) && ((wr_ptr_q + PW'(k)) == PW'(gi))) begin
                    we = 1'b1;
                    wd = push_rec[k];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (we) begin
                slot_q <= wd;
            end
        end

        assign slot_rd[gi] = slot_q;
    end

    assign head  = slot_rd[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/trace_packer.sv
// Commit-trace transmitter: packs retire events into records, dumps statistic
// counters after halt, and streams records out over a valid/ready port.
module trace_packer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [2:0]  wr_reg,
    input  logic [15:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    input  logic [15:0] pc,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_type,
    output logic [2:0]  rec_id,
    output logic [31:0] rec_data,
    output logic        overflow,
    output logic        done
);
    localparam int PW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic               hold_q, hold_d;
    rec_t [MAX_EV-1:0]  held_q, held_d;
    logic [2:0]         held_n_q, held_n_d;
    logic [2:0]         dump_idx_q, dump_idx_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];

    rec_t [MAX_EV-1:0]  raw_rec, ev_rec, push_rec;
    logic [MAX_EV-1:0]  raw_v;
    logic [2:0]         ev_n, push_cnt;
    logic [NUM_CNT-1:0] run_inc;
    logic [PW:0]        fifo_count, free_slots;
    rec_t               head;
    logic               fifo_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Fixed lane order REG, LOAD, STORE, HALT, compacted into ev_rec.
    assign raw_v      = {halt, mem_write, mem_read, reg_write};
    assign raw_rec[0] = make_rec(REC_REG, wr_reg, {16'h0, wr_data});
    assign raw_rec[1] = make_rec(REC_LOAD, 3'd0, {mem_addr, mem_rdata});
    assign raw_rec[2] = make_rec(REC_STORE, 3'd0, {mem_addr, mem_wdata});
    assign raw_rec[3] = make_rec(REC_HALT, 3'd0, {16'h0, pc});

    always_comb begin
        ev_rec = '0;
        ev_n   = '0;
        for (int i = 0; i < MAX_EV; i++) begin
            if (raw_v[i]) begin
                ev_rec[ev_n[1:0]] = raw_rec[i];
                ev_n              = ev_n + 3'd1;
            end
        end
    end

    assign run_inc = {1'b0, dcache_req, icache_req, dcache_hit, icache_hit,
                      halt | reg_write | mem_write, 1'b1};

    assign free_slots = (PW+1)'(DEPTH) - fifo_count;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        held_d     = held_q;
        held_n_d   = held_n_q;
        dump_idx_d = dump_idx_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        push_cnt   = '0;
        push_rec   = '0;

        case (state_q)
            ST_RUN: begin
                if (hold_q) begin
                    // A held list always contains HALT; inputs and counters stay frozen.
                    if (free_slots >= (PW+1)'(held_n_q)) begin
                        push_cnt = held_n_q;
                        push_rec = held_q;
                        hold_d   = 1'b0;
                        state_d  = ST_DUMP;
                    end
                end else begin
                    for (int i = 0; i < NUM_CNT; i++) begin
                        cnt_d[i] = sat_inc(cnt_q[i], run_inc[i]);
                    end
                    if (free_slots >= (PW+1)'(ev_n)) begin
                        push_cnt = ev_n;
                        push_rec = ev_rec;
                        if (halt) begin
                            state_d = ST_DUMP;
                        end
                    end else if (halt) begin
                        hold_d   = 1'b1;
                        held_d   = ev_rec;
                        held_n_d = ev_n;
                    end else begin
                        overflow_d       = 1'b1;
                        cnt_d[CNT_DROPS] = sat_inc(cnt_q[CNT_DROPS], 1'b1);
                    end
                end
            end
            ST_DUMP: begin
                if (free_slots != '0) begin
                    push_cnt    = 3'd1;
                    push_rec[0] = make_rec(REC_COUNT, dump_idx_q, 32'(cnt_q[dump_idx_q]));
                    if (dump_idx_q == CNT_DROPS) begin
                        state_d = ST_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            hold_q     <= 1'b0;
            held_q     <= '0;
            held_n_q   <= '0;
            dump_idx_q <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            held_n_q   <= held_n_d;
            dump_idx_q <= dump_idx_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_cnt(push_cnt),
        .push_rec(push_rec),
        .pop     (rec_ready),
        .head    (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rec_valid = !fifo_empty;
    assign rec_type  = fifo_empty ? 3'd0 : head.rtype;
    assign rec_id    = fifo_empty ? 3'd0 : head.id;
    assign rec_data  = fifo_empty ? 32'd0 : head.data;
    assign overflow  = overflow_q;
    assign done      = (state_q == ST_DONE) && fifo_empty;

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: queue-based reference model checked every
// cycle, plus literal expectations on the consumed record stream.
module tb_trace_packer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam longint unsigned SAT = (longint'(1) << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  wr_reg = '0;
    logic [15:0] wr_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        halt = 1'b0;
    logic [15:0] pc = '0;
    logic        icache_req = 1'b0;
    logic        icache_hit = 1'b0;
    logic        dcache_req = 1'b0;
    logic        dcache_hit = 1'b0;
    logic        rec_valid;
    logic        rec_ready = 1'b1;
    logic [2:0]  rec_type;
    logic [2:0]  rec_id;
    logic [31:0] rec_data;
    logic        overflow;
    logic        done;

    int checks = 0;
    int failures = 0;

    trace_packer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .halt      (halt),
        .pc        (pc),
        .icache_req(icache_req),
        .icache_hit(icache_hit),
        .dcache_req(dcache_req),
        .dcache_hit(dcache_hit),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_type  (rec_type),
        .rec_id    (rec_id),
        .rec_data  (rec_data),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: record queue, counters indexed by COUNT id, trace phase.
    logic [37:0]     mq[$];
    logic [37:0]     held[$];
    logic [37:0]     ev[$];
    logic [37:0]     lg[$];
    longint unsigned mc[7];
    int              m_state;   // 0 run, 1 dump, 2 done
    bit              m_hold;
    bit              m_ovf;
    int              m_didx;
    int              m_free;
    bit              m_pop;

    function automatic longint unsigned sinc(input longint unsigned v, input bit en);
        return (en && v < SAT) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            held.delete();
            for (int i = 0; i < 7; i++) mc[i] = 0;
            m_state = 0;
            m_hold  = 0;
            m_ovf   = 0;
            m_didx  = 0;
        end else begin
            m_free = DEPTH - mq.size();
            m_pop  = (mq.size() > 0) && rec_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_state == 0) begin
                if (m_hold) begin
                    if (m_free >= held.size()) begin
                        foreach (held[i]) mq.push_back(held[i]);
                        held.delete();
                        m_hold  = 0;
                        m_state = 1;
                    end
                end else begin
                    ev.delete();
                    if (reg_write) ev.push_back({3'd1, wr_reg, 16'h0, wr_data});
                    if (mem_read)  ev.push_back({3'd2, 3'd0, mem_addr, mem_rdata});
                    if (mem_write) ev.push_back({3'd3, 3'd0, mem_addr, mem_wdata});
                    if (halt)      ev.push_back({3'd4, 3'd0, 16'h0, pc});
                    mc[0] = sinc(mc[0], 1'b1);
                    mc[1] = sinc(mc[1], halt || reg_write || mem_write);
                    mc[2] = sinc(mc[2], icache_hit);
                    mc[3] = sinc(mc[3], dcache_hit);
                    mc[4] = sinc(mc[4], icache_req);
                    mc[5] = sinc(mc[5], dcache_req);
                    if (ev.size() <= m_free) begin
                        foreach (ev[i]) mq.push_back(ev[i]);
                        if (halt) m_state = 1;
                    end else if (halt) begin
                        held   = ev;
                        m_hold = 1;
                    end else begin
                        m_ovf = 1;
                        mc[6] = sinc(mc[6], 1'b1);
                    end
                end
            end else if (m_state == 1) begin
                if (m_free >= 1) begin
                    mq.push_back({3'd5, 3'(m_didx), 32'(mc[m_didx])});
                    m_didx++;
                    if (m_didx == 7) m_state = 2;
                end
            end
        end
    end

    // Per-cycle compare, stall-stability check and consumed-record log.
    logic [37:0] dut_head;
    logic [37:0] exp_head;
    logic [37:0] stall_head;
    bit          stall_q = 0;

    always @(negedge clk) begin
        dut_head = {rec_type, rec_id, rec_data};
        exp_head = (mq.size() != 0) ? mq[0] : '0;
        chk("rec_valid", rec_valid, mq.size() != 0);
        chk("rec_head", dut_head, exp_head);
        chk("overflow", overflow, m_ovf);
        chk("done", done, (m_state == 2) && (mq.size() == 0));
        if (stall_q && rst) chk("stall_stable", dut_head, stall_head);
        stall_q    = rst && rec_valid && !rec_ready;
        stall_head = dut_head;
        if (!rst) begin
            lg.delete();
        end else if (rec_valid && rec_ready) begin
            lg.push_back(dut_head);
            $display("rec type=%0d id=%0d data=0x%08h", rec_type, rec_id, rec_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_write = 0; wr_reg = '0; wr_data = '0;
        mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
        halt = 0; pc = '0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_inputs();
        rec_ready = 1;
        repeat (2) step();
        rst = 1;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            step();
            n++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic chk_rec(input string name, input int idx, input logic [37:0] exp);
        logic [37:0] got;
        got = (idx < lg.size()) ? lg[idx] : 38'h3F_FFFF_FFFF;
        chk(name, got, exp);
    endtask

    logic [37:0] tmp;

    initial begin
        // T1: reset values, single REG, LOAD, then halt dump
        do_reset();
        chk("t1_rst_valid", rec_valid, 1'b0);
        chk("t1_rst_done", done, 1'b0);
        chk("t1_rst_ovf", overflow, 1'b0);
        chk("t1_rst_data", {rec_type, rec_id, rec_data}, 38'h0);
        reg_write = 1; wr_reg = 3'd3; wr_data = 16'h00AB;
        step();
        idle_inputs();
        chk("t1_reg_valid", rec_valid, 1'b1);
        chk("t1_reg_head", {rec_type, rec_id, rec_data}, {3'd1, 3'd3, 32'h0000_00AB});
        mem_read = 1; mem_addr = 16'h1234; mem_rdata = 16'h5678;
        step();
        idle_inputs();
        halt = 1; pc = 16'h0022;
        step();
        idle_inputs();
        wait_done(60);
        chk("t1_len", lg.size(), 10);
        chk_rec("t1_load", 1, {3'd2, 3'd0, 32'h1234_5678});
        chk_rec("t1_halt", 2, {3'd4, 3'd0, 32'h0000_0022});
        chk_rec("t1_cycles", 3, {3'd5, 3'd0, 32'd3});
        chk_rec("t1_inst", 4, {3'd5, 3'd1, 32'd2});

        // T2: REG + STORE + HALT in one cycle
        do_reset();
        reg_write = 1; wr_reg = 3'd1; wr_data = 16'h1111;
        mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
        halt = 1; pc = 16'h0022;
        step();
        idle_inputs();
        wait_done(60);
        chk("t2_len", lg.size(), 10);
        chk_rec("t2_reg", 0, {3'd1, 3'd1, 32'h0000_1111});
        chk_rec("t2_store", 1, {3'd3, 3'd0, 32'h0040_BEEF});
        chk_rec("t2_halt", 2, {3'd4, 3'd0, 32'h0000_0022});
        chk_rec("t2_cycles", 3, {3'd5, 3'd0, 32'd1});
        chk_rec("t2_inst", 4, {3'd5, 3'd1, 32'd1});
        chk_rec("t2_drops", 9, {3'd5, 3'd6, 32'd0});

        // T3/T4: fill, drop one, halt held while full
        do_reset();
        rec_ready = 0;
        for (int i = 0; i < 8; i++) begin
            reg_write = 1; wr_reg = 3'(i); wr_data = 16'(16'h0100 + i);
            icache_req = 1; icache_hit = (i % 2 == 0);
            step();
        end
        idle_inputs();
        reg_write = 1; wr_reg = 3'd7; wr_data = 16'hDEAD;
        step();
        chk("t3_overflow", overflow, 1'b1);
        idle_inputs();
        halt = 1; pc = 16'h0077;
        step();
        idle_inputs();
        reg_write = 1; dcache_req = 1; dcache_hit = 1;
        repeat (3) step();
        idle_inputs();
        rec_ready = 1;
        wait_done(80);
        chk("t3_len", lg.size(), 16);
        chk_rec("t3_first", 0, {3'd1, 3'd0, 32'h0000_0100});
        chk_rec("t4_halt", 8, {3'd4, 3'd0, 32'h0000_0077});
        chk_rec("t4_cycles", 9, {3'd5, 3'd0, 32'd10});
        chk_rec("t4_inst", 10, {3'd5, 3'd1, 32'd10});
        chk_rec("t4_ihit", 11, {3'd5, 3'd2, 32'd4});
        chk_rec("t4_dhit", 12, {3'd5, 3'd3, 32'd0});
        chk_rec("t4_ireq", 13, {3'd5, 3'd4, 32'd8});
        chk_rec("t3_drops", 15, {3'd5, 3'd6, 32'd1});

        // T5: ready toggling during dump
        do_reset();
        halt = 1; pc = 16'h0005;
        step();
        idle_inputs();
        for (int n = 0; n < 100 && !done; n++) begin
            rec_ready = ~rec_ready;
            step();
        end
        chk("t5_done", done, 1'b1);
        chk("t5_len", lg.size(), 8);
        for (int k = 0; k < 7; k++) begin
            tmp = (k + 1 < lg.size()) ? lg[k + 1] : '0;
            chk("t5_order", tmp[37:32], {3'd5, 3'(k)});
        end
        rec_ready = 1;

        // T6: asynchronous reset mid-dump, then a fresh trace
        do_reset();
        rec_ready = 0;
        for (int i = 0; i < 9; i++) begin
            reg_write = 1; wr_reg = 3'(i); wr_data = 16'(i);
            step();
        end
        idle_inputs();
        chk("t6_overflow", overflow, 1'b1);
        halt = 1; pc = 16'h0009; rec_ready = 1;
        step();
        idle_inputs();
        repeat (4) step();
        chk("t6_in_dump", rec_valid, 1'b1);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk("t6_async_valid", rec_valid, 1'b0);
        chk("t6_async_done", done, 1'b0);
        chk("t6_async_ovf", overflow, 1'b0);
        chk("t6_async_data", rec_data, 32'd0);
        repeat (2) step();
        rst = 1;
        halt = 1; pc = 16'h0033;
        step();
        idle_inputs();
        wait_done(60);
        chk("t6_len", lg.size(), 8);
        chk_rec("t6_halt", 0, {3'd4, 3'd0, 32'h0000_0033});
        chk_rec("t6_cycles", 1, {3'd5, 3'd0, 32'd1});
        chk_rec("t6_inst", 2, {3'd5, 3'd1, 32'd1});
        chk_rec("t6_drops", 7, {3'd5, 3'd6, 32'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/trace_packer.md
# trace_packer

Synthesizable commit-trace transmitter inside the processor. Captures per-cycle retire events (register write, load, store, halt) and cache request/hit strobes, packs them into fixed-format records in a small FIFO, and streams them out over a valid/ready debug port. After halt it appends a counter dump (cycles, instructions, cache statistics), then reports completion.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `CNT_W`, 32: width of every statistic counter; at most 32.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `reg_write`  in  1  register-file write retires this cycle.
- `wr_reg`  in  3  register written.
- `wr_data`  in  16  value written.
- `mem_read` / `mem_write`  in  1 each  load / store completes this cycle.
- `mem_addr`  in  16  memory address.
- `mem_wdata` / `mem_rdata`  in  16 each  store data / load data.
- `halt`  in  1  halt retires this cycle.
- `pc`  in  16  PC of the halting instruction.
- `icache_req` / `icache_hit` / `dcache_req` / `dcache_hit`  in  1 each  cache strobes.
- `rec_valid`  out  1  head record available.
- `rec_ready`  in  1  consumer accepts.
- `rec_type`  out  3  1=REG, 2=LOAD, 3=STORE, 4=HALT, 5=COUNT.
- `rec_id`  out  3  register number (REG), counter index (COUNT), else 0.
- `rec_data`  out  32  payload.
- `overflow`  out  1  sticky: events were dropped.
- `done`  out  1  dump finished and FIFO empty.

## Operation
- Payloads: REG {16'h0, wr_data}; LOAD {mem_addr, mem_rdata}; STORE {mem_addr, mem_wdata}; HALT {16'h0, pc}; COUNT zero-extended counter.
- FSM states RUN, DUMP, DONE; reset to RUN.
- RUN, each cycle: build event list in fixed order REG, LOAD, STORE, HALT (only asserted ones, 0–4 entries). If free slots (DEPTH − count, counted before this cycle's pop) ≥ list length, push all in order; otherwise push none, set `overflow`, increment internal drop counter. HALT is never dropped: if it does not fit, the whole list is held and the FSM stays in a HALT_WAIT sub-condition of RUN, retrying each cycle (later inputs ignored, counters frozen).
- Counters (saturating at all-ones), RUN only: cycles +1 every cycle including the halt cycle; inst +1 when `halt|reg_write|mem_write`; icache_req, icache_hit, dcache_req, dcache_hit +1 on their strobes. Drop counter is counter 6.
- HALT pushed → DUMP. Counters freeze. Emit COUNT ids 0..6 (cycles, inst, icache_hit, dcache_hit, icache_req, dcache_req, drops), one per cycle when ≥1 free slot; stall otherwise, never drop.
- After id 6 pushed → DONE. All inputs ignored; FIFO drains; `done` = DONE && empty.
- Output: `rec_valid` = !empty; `rec_type/id/data` from FIFO head; pop on `rec_valid && rec_ready`. Payload stable while valid and not ready.

## Timing
- Reset values: `rec_valid` 0, `overflow` 0, `done` 0, counters 0, FIFO empty, state RUN; `rec_*` 0 when empty.
- Event in cycle N → `rec_valid` at N+1 earliest (registered storage, no bypass).
- Simultaneous push and pop allowed; full FIFO with pop does not admit a push that cycle.
- Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- Counter saturation: stays at 2^CNT_W−1, no wrap.
- Reset mid-dump: everything returns to reset values immediately; partial records discarded.

## Structure
- Package `trace_pkg`: record type codes, counter index constants, record width (3+3+32), FSM state enum.
- Sub-module `trace_fifo`: circular buffer with up-to-4 pushes per cycle, one pop, `count` output. FSM, counters, and packing live in `trace_packer`.

## Test plan
- Reset, `rec_ready`=1, one cycle reg_write r3=0x00AB → next cycle REG id 3 data 0x000000AB; inst=1.
- Same cycle reg_write r1=0x1111, mem_write 0x0040/0xBEEF, halt pc 0x0022 → REG, STORE 0x0040BEEF, HALT 0x00000022, then COUNT 0..6 with inst=1, cycles = cycles since reset incl. halt cycle.
- `rec_ready`=0, fill 8 REG events, ninth cycle reg_write → dropped, `overflow`=1, drop counter 1 in dump.
- Halt while FIFO full (ready=0 for 4 cycles) → HALT held, pushed once space frees, not dropped, counters frozen during wait.
- `rec_ready` toggled 1/0 during dump → all 7 COUNT records in order, payload stable while stalled; `done` rises one cycle after last pop.
- Assert `rst` low during DUMP → `rec_valid`, `done`, `overflow` 0 asynchronously; next trace restarts counters at 0.
